// File: rtl/bibuf_bus_arbiter_if.sv
// Handshake bundle between the shared-bus requesters and the round-robin arbiter.
//   REQ   : per-requester level request (requesters -> arbiter)
//   GNT   : one-hot registered grant, one BIBUF EN per requester (arbiter -> requesters)
//   OWNER : index of the current or most recent owner
//   BUSY  : arbiter is granting or in a turnaround gap
// slave modport is the arbiter side, master modport is the requester side.
interface bibuf_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQ;
  logic [N-1:0]  GNT;
  logic [PW-1:0] OWNER;
  logic          BUSY;

  modport slave  (input REQ, output GNT, output OWNER, output BUSY);
  modport master (output REQ, input GNT, input OWNER, input BUSY);
endinterface

// File: rtl/bibuf_bus_arbiter.sv
// Round-robin arbiter for one bidirectional pad bus shared by N requesters.
// Grants are one-hot and registered so they can drive tri-state enables
// directly; each tenure is capped at HOLD cycles and followed by TURN dead
// cycles so two drivers never overlap on the pads.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : slave side of bibuf_bus_arbiter_if (REQ in; GNT, OWNER, BUSY out)
module bibuf_bus_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 8,
  parameter int TURN = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  bibuf_bus_arbiter_if.slave      bus
);
  localparam int PW = (N > 1)    ? $clog2(N)    : 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TW = $clog2(TURN + 1);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, GRANT, TURNARD} state_t;

  state_t        state, state_n;
  logic [N-1:0]  gnt, gnt_n;
  logic [PW-1:0] owner, owner_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tc, tc_n;

  logic          win_vld;
  logic [PW-1:0] win;
  int            idx;

  // Rotating priority search from ptr; the wrap is done explicitly so
  // non-power-of-two N never lands on a nonexistent requester.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!win_vld && bus.REQ[idx]) begin
        win_vld = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = '0;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    tc_n    = tc;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n = GRANT;
          gnt_n   = ONE << win;
          owner_n = win;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        // REQ drop and HOLD expiry collapse into the same single release.
        if (!bus.REQ[owner] || cnt == CW'(HOLD - 1)) begin
          state_n = TURNARD;
          tc_n    = '0;
          ptr_n   = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
        end else begin
          gnt_n = gnt;
          cnt_n = cnt + 1'b1;
        end
      end
      TURNARD: begin
        // Only the last dead cycle looks at REQ, using the rotated pointer.
        if (tc == TW'(TURN - 1)) begin
          if (win_vld) begin
            state_n = GRANT;
            gnt_n   = ONE << win;
            owner_n = win;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tc_n = tc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tc    <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      tc    <= tc_n;
    end
  end

  assign bus.GNT   = gnt;
  assign bus.OWNER = owner;
  assign bus.BUSY  = (state != IDLE);
endmodule

// File: tb/tb_bibuf_bus_arbiter.sv
module tb_bibuf_bus_arbiter;
  localparam int N = 4, HOLD = 4, TURN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bibuf_bus_arbiter_if #(.N(N)) bus();
  bibuf_bus_arbiter #(.N(N), .HOLD(HOLD), .TURN(TURN)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
  } vec_t;
  vec_t tbl[$];

  int n_cmp = 0, n_bad = 0;

  // Reference model: who holds the bus, how many cycles it has had it, how
  // many dead cycles remain, where the rotating search starts next.
  int m_holder = -1, m_used = 0, m_gap = 0, m_ptr = 0, m_last = 0;

  task automatic m_pick(input logic [3:0] q);
    for (int i = 0; i < N; i++) begin
      if (m_holder < 0 && q[(m_ptr + i) % N]) begin
        m_holder = (m_ptr + i) % N;
        m_used   = 1;
        m_last   = m_holder;
      end
    end
  endtask

  task automatic m_edge(input logic r, input logic [3:0] q);
    if (r) begin
      m_holder = -1; m_used = 0; m_gap = 0; m_ptr = 0; m_last = 0;
    end else if (m_holder >= 0) begin
      if (!q[m_holder] || m_used == HOLD) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
        m_gap    = TURN;
      end else m_used++;
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      m_pick(q);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] q);
    rst     = r;
    bus.REQ = q;
    @(posedge clk);
    m_edge(r, q);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eo, input logic eb);
    n_cmp++;
    if (bus.GNT !== eg || bus.OWNER !== eo || bus.BUSY !== eb) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
               nm, bus.GNT, bus.OWNER, bus.BUSY, eg, eo, eb);
    end
  endtask

  task automatic chk_model(input string nm);
    logic [3:0] eg;
    eg = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
    chk(nm, eg, 2'(m_last), (m_holder >= 0) || (m_gap > 0));
  endtask

  initial begin
    logic [3:0] rq;
    int run, max_run;
    bus.REQ = '0;

    // Reset, then fairness under REQ=1111: four on, one dead, rotating.
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
    for (int o = 0; o < N; o++) begin
      for (int c = 0; c < HOLD; c++)
        tbl.push_back('{1'b0, 4'b1111, 4'b0001 << o, 2'(o), 1'b1});
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 2'(o), 1'b1});
    end
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].req);
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].own, tbl[i].busy);
    end

    // Early release: REQ[1] for three edges, then dropped.
    cyc(1'b1, 4'b0000); chk("er_rst", 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0010); chk($sformatf("er_g%0d", i), 4'b0010, 2'd1, 1'b1);
    end
    cyc(1'b0, 4'b0000); chk("er_turn", 4'b0000, 2'd1, 1'b1);
    cyc(1'b0, 4'b0000); chk("er_idle", 4'b0000, 2'd1, 1'b0);

    // Pointer wrap: owner 3 releases, PTR wraps to 0, so 1001 goes to 0.
    cyc(1'b1, 4'b0000);
    cyc(1'b0, 4'b1000); chk("pw_g3", 4'b1000, 2'd3, 1'b1);
    cyc(1'b0, 4'b0000); chk("pw_turn", 4'b0000, 2'd3, 1'b1);
    cyc(1'b0, 4'b1001); chk("pw_g0", 4'b0001, 2'd0, 1'b1);
    cyc(1'b0, 4'b1000); chk("pw_turn2", 4'b0000, 2'd0, 1'b1);
    cyc(1'b0, 4'b1000); chk("pw_g3b", 4'b1000, 2'd3, 1'b1);

    // Reset in the 3rd grant cycle of owner 1; PTR must restart at 0.
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0010);
    chk("rm_pre", 4'b0010, 2'd1, 1'b1);
    cyc(1'b1, 4'b0010); chk("rm_rst", 4'b0000, 2'd0, 1'b0);
    cyc(1'b0, 4'b0011); chk("rm_g0", 4'b0001, 2'd0, 1'b1);

    // Single hog: grant never exceeds HOLD consecutive cycles.
    cyc(1'b1, 4'b0000);
    run = 0; max_run = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 4'b0100);
      chk_model($sformatf("hog%0d", i));
      run = bus.GNT[2] ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    n_cmp++;
    if (max_run != HOLD) begin
      n_bad++;
      $display("FAIL hog_run: got longest tenure %0d, want %0d", max_run, HOLD);
    end

    // Random traffic against the model, with occasional resets.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 63) == 0, rq);
      chk_model($sformatf("rnd%0d", i));
      n_cmp++;
      if (!$onehot0(bus.GNT)) begin
        n_bad++;
        $display("FAIL rnd_onehot%0d: got gnt=%b, want at most one bit", i, bus.GNT);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
